// File: rtl/fp_class_seq_pkg.sv
// Shared definitions for the IEEE-754 classifier: class flag indices,
// FSM state encoding and exponent bias helpers.
package fp_class_seq_pkg;

    localparam int SNAN      = 0;
    localparam int QNAN      = 1;
    localparam int INFINITY  = 2;
    localparam int ZERO      = 3;
    localparam int SUBNORMAL = 4;
    localparam int NORMAL    = 5;
    localparam int LAST_FLAG = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int bias_of(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

    function automatic int emin_of(input int nexp);
        return 1 - bias_of(nexp);
    endfunction

endpackage

// File: rtl/fp_class_seq_norm_step.sv
// One binary-search normalisation step: shift sig left by i when its
// top i bits are all zero.
module fp_norm_step #(
    parameter int W = 11,
    parameter int S = 4
) (
    input  logic [W-1:0] sig,
    input  logic [S-1:0] i,
    output logic [W-1:0] sig_next,
    output logic         taken
);

    always_comb begin
        taken = 1'b1;
        for (int k = 0; k < W; k++) begin
            if ((k >= W - int'(i)) && sig[k]) begin
                taken = 1'b0;
            end
        end
        sig_next = taken ? (sig << i) : sig;
    end

endmodule

// File: rtl/fp_class_seq.sv
// Sequential IEEE-754 classifier/unpacker with iterative subnormal
// normalisation; define FP_CLASS_SEQ_DAZ_EN to flush subnormals to zero.
module fp_class_seq
    import fp_class_seq_pkg::*;
#(
    parameter int NEXP       = 5,
    parameter int NSIG       = 10,
    parameter int CLOG2_NSIG = $clog2(NSIG + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NEXP+NSIG:0]         in_f,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sign,
    output logic signed [NEXP+1:0]     out_exp,
    output logic [NSIG:0]              out_sig,
    output logic [LAST_FLAG-1:0]       out_flags
);

    localparam int W    = NSIG + 1;
    localparam int EW   = NEXP + 2;
    localparam int S    = CLOG2_NSIG;
    localparam int BIAS = bias_of(NEXP);
    localparam int EMIN = emin_of(NEXP);

    state_t state;

    logic [NEXP-1:0] e;
    logic [NSIG-1:0] m;
    logic            e_ones, e_zero, m_zero;
    logic            accept;

    state_t               ld_state;
    logic                 ld_valid;
    logic [EW-1:0]        ld_exp;
    logic [W-1:0]         ld_sig;
    logic [LAST_FLAG-1:0] ld_flags;

    assign e      = in_f[NSIG +: NEXP];
    assign m      = in_f[NSIG-1:0];
    assign e_ones = &e;
    assign e_zero = ~|e;
    assign m_zero = ~|m;

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        ld_state = DONE;
        ld_valid = 1'b1;
        ld_exp   = EW'(e);
        ld_sig   = {1'b0, m};
        ld_flags = '0;
        unique case (1'b1)
            e_ones & m_zero:                 ld_flags[INFINITY] = 1'b1;
            e_ones & m[NSIG-1]:              ld_flags[QNAN]     = 1'b1;
            e_ones & ~m_zero & ~m[NSIG-1]:   ld_flags[SNAN]     = 1'b1;
            e_zero & m_zero:                 ld_flags[ZERO]     = 1'b1;
            e_zero & ~m_zero: begin
`ifdef FP_CLASS_SEQ_DAZ_EN
                ld_flags[ZERO] = 1'b1;
                ld_sig         = '0;
`else
                ld_flags[SUBNORMAL] = 1'b1;
                ld_state            = NORM;
                ld_valid            = 1'b0;
`endif
            end
            default: begin
                ld_flags[NORMAL] = 1'b1;
                ld_exp           = EW'(e) - EW'(BIAS);
                ld_sig           = {1'b1, m};
            end
        endcase
    end

`ifndef FP_CLASS_SEQ_DAZ_EN
    localparam logic [S-1:0] I0 = S'(1 << (S - 1));

    logic [S-1:0] i;
    logic [S-1:0] sa;
    logic [S-1:0] sa_n;
    logic [W-1:0] step_sig;
    logic         taken;

    // out_sig doubles as the working significand while in NORM
    fp_norm_step #(
        .W (W),
        .S (S)
    ) u_step (
        .sig      (out_sig),
        .i        (i),
        .sig_next (step_sig),
        .taken    (taken)
    );

    assign sa_n = sa | (taken ? i : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_sig   <= '0;
            out_flags <= '0;
`ifndef FP_CLASS_SEQ_DAZ_EN
            i         <= '0;
            sa        <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= ld_state;
                        out_valid <= ld_valid;
                        out_sign  <= in_f[NEXP+NSIG];
                        out_exp   <= ld_exp;
                        out_sig   <= ld_sig;
                        out_flags <= ld_flags;
`ifndef FP_CLASS_SEQ_DAZ_EN
                        i         <= I0;
                        sa        <= '0;
`endif
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifndef FP_CLASS_SEQ_DAZ_EN
                NORM: begin
                    out_sig <= step_sig;
                    sa      <= sa_n;
                    i       <= i >> 1;
                    if (i == S'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_exp   <= EW'(EMIN) - EW'(sa_n);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_class_seq.sv
// Randomised self-checking bench for fp_class_seq (binary16 defaults).
module tb_fp_class_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_f;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic signed [6:0] out_exp;
    logic [10:0] out_sig;
    logic [5:0]  out_flags;

    fp_class_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sign;
        int   exp;
        int   sig;
        int   flags;
        bit   sub;
        int   due;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: binary16 decode from the class rules
    function automatic res_t model(logic [15:0] f);
        res_t r;
        int e, m, p;
        e = int'(f[14:10]);
        m = int'(f[9:0]);
        r.sign = f[15];
        r.sub  = 1'b0;
        r.due  = 0;
        if (e == 31) begin
            r.exp = 31;
            r.sig = m;
            if (m == 0)             r.flags = 1 << 2;
            else if (m >= 512)      r.flags = 1 << 1;
            else                    r.flags = 1 << 0;
        end else if (e == 0 && m == 0) begin
            r.exp = 0;
            r.sig = 0;
            r.flags = 1 << 3;
        end else if (e == 0) begin
            p = 0;
            for (int b = 0; b < 10; b++) if ((m >> b) & 1) p = b;
            r.exp = -14 - (10 - p);
            r.sig = m << (10 - p);
            r.flags = 1 << 4;
            r.sub = 1'b1;
        end else begin
            r.exp = e - 15;
            r.sig = 1024 + m;
            r.flags = 1 << 5;
        end
        return r;
    endfunction

    task automatic step(logic iv, logic [15:0] f, logic ordy);
        bit   ev, er;
        res_t r;
        @(negedge clk);
        ev = (q.size() > 0) && (cyc >= q[0].due);
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            check("sign", 32'(out_sign), 32'(q[0].sign));
            check("exp", {25'b0, out_exp}, 32'(q[0].exp) & 32'h7f);
            check("sig", 32'(out_sig), 32'(q[0].sig));
            check("flags", 32'(out_flags), 32'(q[0].flags));
        end
        in_valid  = iv;
        in_f      = f;
        out_ready = ordy;
        #1;
        er = (q.size() == 0) || (ev && ordy);
        check("in_ready", 32'(in_ready), 32'(er));
        if (ev && ordy) void'(q.pop_front());
        if (iv && er) begin
            r = model(f);
            r.due = cyc + 1 + (r.sub ? 4 : 0);
            q.push_back(r);
        end
    endtask

    task automatic check_zero_outputs();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sign", 32'(out_sign), 32'd0);
        check("rst_exp", {25'b0, out_exp}, 32'd0);
        check("rst_sig", 32'(out_sig), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero_outputs();
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_f();
        logic [15:0] f;
        f = 16'($urandom);
        case ($urandom_range(0, 4))
            0: f[14:0] = {5'd0, 10'($urandom_range(1, 1023))};
            1: f[14:10] = 5'h1f;
            2: f[14:0] = 15'd0;
            default: ;
        endcase
        return f;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_f      = '0;
        out_ready = 1'b0;
        #1;
        check_zero_outputs();
        @(negedge clk);
        rst = 1'b0;

        step(1, 16'h3C00, 1);
        step(0, 16'h0000, 1);
        step(1, 16'h0001, 1);
        repeat (6) step(0, 16'h0000, 1);

        step(1, 16'h7C00, 1);
        step(1, 16'h7E00, 1);
        step(1, 16'h7D00, 1);
        step(1, 16'h8000, 1);
        step(0, 16'h0000, 1);

        step(1, 16'h3C00, 1);
        step(1, 16'h4000, 1);
        step(1, 16'h4400, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        step(1, 16'h4000, 0);
        repeat (3) step(1, 16'h5555, 0);
        step(1, 16'h4400, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        step(1, 16'h0001, 1);
        step(0, 16'h0000, 1);
        do_reset();
        step(1, 16'h3C00, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, rand_f(), $urandom_range(0, 3) != 0);
        end
        repeat (8) step(0, 16'h0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
